// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous single-port DMEM between the core MEM
// stage and a loader/debug port. One access is issued per cycle. A read returns
// on MEM_DOUT the following cycle. A saturating wait counter stops the loader
// from being starved by continuous core traffic.
//
// state       | meaning
// ------------+-----------------------------------------------------
// S_IDLE      | no read data pending on MEM_DOUT this cycle
// S_CORE_DATA | core read issued last cycle, its data is on MEM_DOUT
// S_LD_DATA   | loader read issued last cycle, its data is on MEM_DOUT
module dmem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          CORE_RD,
  input  logic          CORE_W,
  input  logic [AW-1:0] CORE_ADD,
  input  logic [DW-1:0] CORE_DIN,
  output logic [DW-1:0] CORE_DOUT,
  output logic          CORE_STALL,
  input  logic          LD_REQ,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADD,
  input  logic [DW-1:0] LD_DIN,
  output logic          LD_GNT,
  output logic          LD_RVALID,
  output logic [DW-1:0] LD_DOUT,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADD,
  output logic [DW-1:0] MEM_DIN,
  input  logic [DW-1:0] MEM_DOUT
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE_DATA,
    S_LD_DATA
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [DW-1:0]  core_dout_q;
  logic [DW-1:0]  ld_dout_q;
  logic           core_req;
  logic           ld_issue;
  logic           core_issue;

  // State register, loader wait counter and held read-data registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      core_dout_q <= '0;
      ld_dout_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_CORE_DATA) core_dout_q <= MEM_DOUT;
      if (state_q == S_LD_DATA)   ld_dout_q   <= MEM_DOUT;
    end
  end

  // Arbitration, DMEM drive, core stall and next-state / wait-count logic.
  always_comb begin
    state_d    = S_IDLE;
    wait_d     = '0;
    LD_GNT     = 1'b0;
    MEM_CS     = 1'b0;
    MEM_WE     = 1'b0;
    MEM_ADD    = '0;
    MEM_DIN    = '0;
    CORE_STALL = 1'b0;

    // The core request seen in S_CORE_DATA is the one completing now.
    core_req   = (CORE_RD | CORE_W) && (state_q != S_CORE_DATA);
    ld_issue   = LD_REQ && (!core_req || (wait_q == WAIT_SAT));
    core_issue = core_req && !ld_issue;

    if (ld_issue) begin
      LD_GNT  = 1'b1;
      MEM_CS  = 1'b1;
      MEM_WE  = LD_WE;
      MEM_ADD = LD_ADD;
      MEM_DIN = LD_DIN;
      if (!LD_WE) state_d = S_LD_DATA;
    end else if (core_issue) begin
      MEM_CS  = 1'b1;
      MEM_WE  = CORE_W;
      MEM_ADD = CORE_ADD;
      MEM_DIN = CORE_DIN;
      if (!CORE_W) state_d = S_CORE_DATA;
    end

    // Stall while losing arbitration, or for the issue cycle of a core load.
    CORE_STALL = (core_req && !core_issue) || (core_issue && !CORE_W);

    if (LD_REQ && !ld_issue) begin
      wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WCW'(1);
    end
  end

  // Read data is passed straight through in its data cycle and held after.
  assign CORE_DOUT = (state_q == S_CORE_DATA) ? MEM_DOUT : core_dout_q;
  assign LD_RVALID = (state_q == S_LD_DATA);
  assign LD_DOUT   = (state_q == S_LD_DATA) ? MEM_DOUT : ld_dout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run checked against a
// cycle-level behavioural model of the arbiter and of memory contents.
module tb_dmem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          CORE_RD, CORE_W;
  logic [AW-1:0] CORE_ADD;
  logic [DW-1:0] CORE_DIN;
  logic [DW-1:0] CORE_DOUT;
  logic          CORE_STALL;
  logic          LD_REQ, LD_WE;
  logic [AW-1:0] LD_ADD;
  logic [DW-1:0] LD_DIN;
  logic          LD_GNT, LD_RVALID;
  logic [DW-1:0] LD_DOUT;
  logic          MEM_CS, MEM_WE;
  logic [AW-1:0] MEM_ADD;
  logic [DW-1:0] MEM_DIN;
  logic [DW-1:0] MEM_DOUT = '0;

  logic [DW-1:0] mem [0:255] = '{default: '0};

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CORE_RD(CORE_RD), .CORE_W(CORE_W), .CORE_ADD(CORE_ADD), .CORE_DIN(CORE_DIN),
    .CORE_DOUT(CORE_DOUT), .CORE_STALL(CORE_STALL),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADD(LD_ADD), .LD_DIN(LD_DIN),
    .LD_GNT(LD_GNT), .LD_RVALID(LD_RVALID), .LD_DOUT(LD_DOUT),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADD(MEM_ADD), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port DMEM: read data appears the cycle after issue.
  always @(posedge CLK) begin
    if (MEM_CS) begin
      if (MEM_WE) mem[MEM_ADD[7:0]] <= MEM_DIN;
      else        MEM_DOUT <= mem[MEM_ADD[7:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    CORE_RD = 0; CORE_W = 0; CORE_ADD = '0; CORE_DIN = '0;
    LD_REQ = 0; LD_WE = 0; LD_ADD = '0; LD_DIN = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 0;
    #1;
    checks++; if (MEM_CS !== 0 || MEM_WE !== 0 || LD_GNT !== 0 || CORE_STALL !== 0) begin
      errors++; $display("FAIL reset_idle_outputs cs=%b we=%b gnt=%b stall=%b exp all 0", MEM_CS, MEM_WE, LD_GNT, CORE_STALL);
    end
    CORE_W = 1; LD_REQ = 1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (LD_RVALID !== 0 || CORE_DOUT !== 0 || LD_DOUT !== 0) begin
      errors++; $display("FAIL reset_regs rvalid=%b core_dout=%h ld_dout=%h exp 0", LD_RVALID, CORE_DOUT, LD_DOUT);
    end
    @(negedge CLK);
    RSTn = 1;
    #1;
    checks++; if (MEM_CS !== 1 || MEM_WE !== 1 || LD_GNT !== 0 || CORE_STALL !== 0) begin
      errors++; $display("FAIL reset_first_issue cs=%b we=%b gnt=%b stall=%b exp 1 1 0 0", MEM_CS, MEM_WE, LD_GNT, CORE_STALL);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_core_rw();
    @(negedge CLK);
    CORE_W = 1; CORE_ADD = 30'h10; CORE_DIN = 32'hDEADBEEF;
    #1;
    checks++; if (CORE_STALL !== 0 || MEM_CS !== 1 || MEM_WE !== 1 || MEM_ADD !== 30'h10 || MEM_DIN !== 32'hDEADBEEF) begin
      errors++; $display("FAIL core_store stall=%b cs=%b we=%b add=%h din=%h exp 0 1 1 10 deadbeef", CORE_STALL, MEM_CS, MEM_WE, MEM_ADD, MEM_DIN);
    end
    @(negedge CLK);
    CORE_W = 0; CORE_RD = 1;
    #1;
    checks++; if (CORE_STALL !== 1 || MEM_CS !== 1 || MEM_WE !== 0) begin
      errors++; $display("FAIL core_load_issue stall=%b cs=%b we=%b exp 1 1 0", CORE_STALL, MEM_CS, MEM_WE);
    end
    @(negedge CLK);
    #1;
    checks++; if (CORE_STALL !== 0 || CORE_DOUT !== 32'hDEADBEEF || MEM_CS !== 0) begin
      errors++; $display("FAIL core_load_data stall=%b dout=%h cs=%b exp 0 deadbeef 0", CORE_STALL, CORE_DOUT, MEM_CS);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (CORE_DOUT !== 32'hDEADBEEF) begin
      errors++; $display("FAIL core_dout_hold got=%h exp=deadbeef", CORE_DOUT);
    end
  endtask

  task automatic test_loader_rw();
    @(negedge CLK);
    LD_REQ = 1; LD_WE = 1; LD_ADD = 30'h20; LD_DIN = 32'h12345678;
    #1;
    checks++; if (LD_GNT !== 1 || MEM_WE !== 1 || MEM_ADD !== 30'h20 || MEM_DIN !== 32'h12345678) begin
      errors++; $display("FAIL ld_write gnt=%b we=%b add=%h din=%h exp 1 1 20 12345678", LD_GNT, MEM_WE, MEM_ADD, MEM_DIN);
    end
    @(negedge CLK);
    LD_WE = 0;
    #1;
    checks++; if (LD_GNT !== 1 || MEM_WE !== 0 || LD_RVALID !== 0) begin
      errors++; $display("FAIL ld_read_issue gnt=%b we=%b rvalid=%b exp 1 0 0", LD_GNT, MEM_WE, LD_RVALID);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (LD_RVALID !== 1 || LD_DOUT !== 32'h12345678) begin
      errors++; $display("FAIL ld_read_data rvalid=%b dout=%h exp 1 12345678", LD_RVALID, LD_DOUT);
    end
    @(negedge CLK);
    #1;
    checks++; if (LD_RVALID !== 0 || LD_DOUT !== 32'h12345678) begin
      errors++; $display("FAIL ld_rvalid_pulse rvalid=%b dout=%h exp 0 12345678", LD_RVALID, LD_DOUT);
    end
  endtask

  task automatic test_contention();
    @(negedge CLK);
    CORE_W = 1; CORE_ADD = 30'h30; CORE_DIN = 32'hA5A50030;
    LD_REQ = 1; LD_WE = 0; LD_ADD = 30'h20;
    for (int i = 1; i <= MAX_WAIT + 1; i++) begin
      #1;
      checks++; if (LD_GNT !== (i == MAX_WAIT + 1) || CORE_STALL !== (i == MAX_WAIT + 1)) begin
        errors++; $display("FAIL contention cyc=%0d gnt=%b stall=%b exp %0b", i, LD_GNT, CORE_STALL, (i == MAX_WAIT + 1));
      end
      @(negedge CLK);
    end
    #1;
    checks++; if (LD_GNT !== 0 || LD_RVALID !== 1 || LD_DOUT !== 32'h12345678 || CORE_STALL !== 0) begin
      errors++; $display("FAIL contention_after gnt=%b rvalid=%b dout=%h stall=%b exp 0 1 12345678 0", LD_GNT, LD_RVALID, LD_DOUT, CORE_STALL);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_overlap();
    @(negedge CLK);
    CORE_RD = 1; CORE_ADD = 30'h10;
    #1;
    checks++; if (CORE_STALL !== 1) begin
      errors++; $display("FAIL overlap_issue stall=%b exp 1", CORE_STALL);
    end
    @(negedge CLK);
    LD_REQ = 1; LD_WE = 0; LD_ADD = 30'h30;
    #1;
    checks++; if (LD_GNT !== 1 || CORE_STALL !== 0 || CORE_DOUT !== 32'hDEADBEEF || MEM_ADD !== 30'h30) begin
      errors++; $display("FAIL overlap_data gnt=%b stall=%b dout=%h add=%h exp 1 0 deadbeef 30", LD_GNT, CORE_STALL, CORE_DOUT, MEM_ADD);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (LD_RVALID !== 1 || LD_DOUT !== 32'hA5A50030) begin
      errors++; $display("FAIL overlap_ld rvalid=%b dout=%h exp 1 a5a50030", LD_RVALID, LD_DOUT);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK);
    LD_REQ = 1; LD_WE = 0; LD_ADD = 30'h10;
    #1;
    checks++; if (LD_GNT !== 1) begin
      errors++; $display("FAIL midrst_grant gnt=%b exp 1", LD_GNT);
    end
    #1;
    RSTn = 0;
    idle_inputs();
    @(negedge CLK);
    #1;
    checks++; if (LD_RVALID !== 0 || LD_DOUT !== 0 || CORE_DOUT !== 0) begin
      errors++; $display("FAIL midrst_in_reset rvalid=%b ld_dout=%h core_dout=%h exp 0 0 0", LD_RVALID, LD_DOUT, CORE_DOUT);
    end
    @(negedge CLK);
    RSTn = 1;
    #1;
    checks++; if (LD_RVALID !== 0 || MEM_CS !== 0) begin
      errors++; $display("FAIL midrst_release rvalid=%b cs=%b exp 0 0", LD_RVALID, MEM_CS);
    end
    @(negedge CLK);
    CORE_RD = 1; CORE_ADD = 30'h10;
    #1;
    checks++; if (LD_RVALID !== 0 || CORE_STALL !== 1 || MEM_CS !== 1) begin
      errors++; $display("FAIL midrst_idle rvalid=%b stall=%b cs=%b exp 0 1 1", LD_RVALID, CORE_STALL, MEM_CS);
    end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
  endtask

  // Random traffic against a model that tracks which requester has data in
  // flight, how long the loader has waited, and what memory should contain.
  task automatic test_random();
    int pend = 0;          // 0 none, 1 core read data due, 2 loader read data due
    int pend_idx = 0;
    int waited = 0;
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    logic [DW-1:0] core_hold = '0, ld_hold = '0;
    bit core_wants, ld_go, core_go, exp_cs, exp_we, exp_stall, exp_rv;
    logic [AW-1:0] exp_add;
    logic [DW-1:0] exp_din, exp_cd, exp_ld;

    @(negedge CLK);
    RSTn = 0;
    idle_inputs();
    @(negedge CLK);
    RSTn = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      CORE_RD  = ($urandom_range(0, 2) == 0);
      CORE_W   = ($urandom_range(0, 3) == 0);
      CORE_ADD = 30'h80 | 30'($urandom_range(0, 15));
      CORE_DIN = $urandom;
      LD_REQ   = ($urandom_range(0, 1) == 1);
      LD_WE    = ($urandom_range(0, 1) == 1);
      LD_ADD   = 30'h80 | 30'($urandom_range(0, 15));
      LD_DIN   = $urandom;
      #1;
      core_wants = (CORE_RD || CORE_W) && (pend != 1);
      ld_go      = LD_REQ && (!core_wants || waited >= MAX_WAIT);
      core_go    = core_wants && !ld_go;
      exp_cs     = core_go || ld_go;
      exp_we     = ld_go ? LD_WE : (core_go ? CORE_W : 1'b0);
      exp_add    = ld_go ? LD_ADD : CORE_ADD;
      exp_din    = ld_go ? LD_DIN : CORE_DIN;
      exp_stall  = core_wants && (!core_go || !CORE_W);
      exp_rv     = (pend == 2);
      exp_cd     = (pend == 1) ? ref_mem[pend_idx] : core_hold;
      exp_ld     = (pend == 2) ? ref_mem[pend_idx] : ld_hold;

      checks++; if (MEM_CS !== exp_cs) begin
        errors++; $display("FAIL rnd_cs cyc=%0d got=%b exp=%b", c, MEM_CS, exp_cs);
      end
      checks++; if (MEM_WE !== exp_we) begin
        errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, MEM_WE, exp_we);
      end
      checks++; if (LD_GNT !== ld_go) begin
        errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b wait=%0d", c, LD_GNT, ld_go, waited);
      end
      checks++; if (CORE_STALL !== exp_stall) begin
        errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, CORE_STALL, exp_stall);
      end
      checks++; if (LD_RVALID !== exp_rv) begin
        errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, LD_RVALID, exp_rv);
      end
      checks++; if (CORE_DOUT !== exp_cd) begin
        errors++; $display("FAIL rnd_core_dout cyc=%0d got=%h exp=%h", c, CORE_DOUT, exp_cd);
      end
      checks++; if (LD_DOUT !== exp_ld) begin
        errors++; $display("FAIL rnd_ld_dout cyc=%0d got=%h exp=%h", c, LD_DOUT, exp_ld);
      end
      if (exp_cs) begin
        checks++; if (MEM_ADD !== exp_add || (exp_we && MEM_DIN !== exp_din)) begin
          errors++; $display("FAIL rnd_addr_data cyc=%0d add=%h din=%h exp %h %h", c, MEM_ADD, MEM_DIN, exp_add, exp_din);
        end
      end

      core_hold = exp_cd;
      ld_hold   = exp_ld;
      if (exp_cs && exp_we) ref_mem[exp_add[3:0]] = exp_din;
      if (exp_cs && !exp_we) begin
        pend     = ld_go ? 2 : 1;
        pend_idx = int'(exp_add[3:0]);
      end else begin
        pend = 0;
      end
      if (LD_REQ && !ld_go) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
      else                  waited = 0;
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_loader_rw();
    test_contention();
    test_overlap();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
